// File: rtl/layer_sequencer.sv
// Descriptor-table scheduler for the conv/maxp/dense/result engines; optional watchdog via LAYER_SEQ_TIMEOUT_EN.
// Latency: go->start 2 cycles, stop->next start 2 (same layer) / 3 (next layer); waits on engine stop level.
module layer_sequencer #(
    parameter int NUM_LAYERS       = 16,
    parameter int SIZE_address_pix = 13,
    parameter int PIC_LIMIT        = 784,
    parameter int PIC_LIMIT_2      = 3136,
    parameter int TIMEOUT          = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0] cfg_addr,
    input  logic [15:0]                   cfg_data,
    input  logic                          go,
    input  logic [3:0]                    eng_stop,
    output logic [3:0]                    eng_start,
    output logic [3:0]                    eng_en,
    output logic [SIZE_address_pix-1:0]   memstartp,
    output logic [SIZE_address_pix-1:0]   memstartzap,
    output logic [4:0]                    matrix,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam int AW = SIZE_address_pix;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT} state_t;

    state_t       state, state_nxt;
    logic [15:0]  table_q [NUM_LAYERS];
    logic [15:0]  desc_q;
    logic [3:0]   pass_q;
    logic [15:0]  fetch_desc;
    logic         fetch_bad;
    logic         stop_hit;
    logic         last_pass;
    logic         run_end;
    logic         wd_hit;

    logic [15:0]  a_desc;
    logic [3:0]   a_pass;
    logic [9:0]   m2;
    logic [9:0]   dst_step;
    logic [AW-1:0] addr_p, addr_z;

    function automatic logic [AW-1:0] region_base(input logic [1:0] r);
        case (r)
            2'd1:    return AW'(PIC_LIMIT);
            2'd2:    return AW'(PIC_LIMIT_2);
            default: return '0;
        endcase
    endfunction

    assign fetch_desc = table_q[layer_idx];
    assign fetch_bad  = (fetch_desc[3:2] == 2'd3) || (fetch_desc[5:4] == 2'd3);
    assign stop_hit   = eng_stop[desc_q[1:0]];
    assign last_pass  = (pass_q == desc_q[15:12]);
    assign run_end    = desc_q[11] || (layer_idx == LW'(NUM_LAYERS - 1));

    // FETCH loads pass 0 of the new descriptor, NEXT loads the following pass of the held one
    assign a_desc   = (state == S_FETCH) ? fetch_desc : desc_q;
    assign a_pass   = (state == S_FETCH) ? 4'd0 : pass_q + 4'd1;
    assign m2       = {5'd0, a_desc[10:6]} * {5'd0, a_desc[10:6]};
    assign dst_step = (a_desc[1:0] == 2'd1) ? (m2 >> 2) : m2;
    assign addr_p   = region_base(a_desc[3:2]) + AW'(a_pass) * AW'(m2);
    assign addr_z   = region_base(a_desc[5:4]) + AW'(a_pass) * AW'(dst_step);

`ifdef LAYER_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;
    assign wd_hit = (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)                    wd_cnt <= '0;
        else if (state == S_ISSUE)  wd_cnt <= '0;
        else if (state == S_WAIT)   wd_cnt <= wd_cnt + 16'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Table is deliberately not reset; writes only land while idle
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && state == S_IDLE)
            table_q[cfg_addr] <= cfg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            desc_q      <= '0;
            pass_q      <= '0;
            layer_idx   <= '0;
            memstartp   <= '0;
            memstartzap <= '0;
            matrix      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    layer_idx <= '0;
                    err       <= 1'b0;
                end
                S_FETCH: begin
                    desc_q <= fetch_desc;
                    pass_q <= '0;
                    if (fetch_bad) begin
                        err <= 1'b1;
                    end else begin
                        memstartp   <= addr_p;
                        memstartzap <= addr_z;
                        matrix      <= fetch_desc[10:6];
                    end
                end
                S_WAIT: if (!stop_hit && wd_hit) err <= 1'b1;
                S_NEXT: begin
                    if (!last_pass) begin
                        pass_q      <= pass_q + 4'd1;
                        memstartp   <= addr_p;
                        memstartzap <= addr_z;
                    end else if (run_end) begin
                        done <= 1'b1;
                    end else begin
                        layer_idx <= layer_idx + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_FETCH;
            S_FETCH: state_nxt = fetch_bad ? S_IDLE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (stop_hit)    state_nxt = S_NEXT;
                else if (wd_hit) state_nxt = S_IDLE;
            end
            S_NEXT: begin
                if (!last_pass)   state_nxt = S_ISSUE;
                else if (run_end) state_nxt = S_IDLE;
                else              state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        eng_start = 4'b0000;
        eng_en    = 4'b0000;
        busy      = (state != S_IDLE);
        if (state == S_ISSUE)
            eng_start = 4'b0001 << desc_q[1:0];
        if (state == S_ISSUE || state == S_WAIT)
            eng_en = 4'b0001 << desc_q[1:0];
    end
endmodule
